// File: rtl/ddeglitch_pkg.sv
// ddeglitch_pkg: shared types and helpers for the deglitching receive cell.
//   state_t   : filter FSM states (IDLE, STABLE, QUAL)
//   *_W_DEF   : default widths of the filter-length input and glitch counter
//   eff_n()   : effective qualify length, max(filt_cnt, 1)
package ddeglitch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STABLE = 2'd1,
      QUAL   = 2'd2
   } state_t;

   localparam int FILT_W_DEF = 4;
   localparam int GCNT_W_DEF = 8;

   // Working width for filter-length arithmetic; wide enough that cnt + 1
   // never wraps for any supported FILT_W.
   localparam int NW = 16;

   // A programmed length of zero behaves exactly like a length of one.
   function automatic logic [NW-1:0] eff_n(input logic [NW-1:0] filt);
      return (filt == '0) ? NW'(1) : filt;
   endfunction

endpackage

// File: rtl/ddeglitch_rx_if.sv
// ddeglitch_rx_if: control/status bundle of the deglitching receiver.
//   en, i, filt_cnt, glitch_clr   : driven by the master (controller side)
//   o, o_rise, o_fall, busy,
//   glitch_cnt                     : driven by the slave (ddeglitch_rx)
interface ddeglitch_rx_if
   import ddeglitch_pkg::*;
#(
   parameter int FILT_W = FILT_W_DEF,
   parameter int GCNT_W = GCNT_W_DEF
);
   logic              en;
   logic              i;
   logic [FILT_W-1:0] filt_cnt;
   logic              glitch_clr;
   logic              o;
   logic              o_rise;
   logic              o_fall;
   logic              busy;
   logic [GCNT_W-1:0] glitch_cnt;

   modport master (
      output en, i, filt_cnt, glitch_clr,
      input  o, o_rise, o_fall, busy, glitch_cnt
   );

   modport slave (
      input  en, i, filt_cnt, glitch_clr,
      output o, o_rise, o_fall, busy, glitch_cnt
   );
endinterface

// File: rtl/dsync_chain.sv
// dsync_chain: plain multi-flop synchronizer for an asynchronous level.
//   clk  : destination clock
//   rstb : asynchronous active-low reset, all flops load RST_VAL
//   d    : asynchronous input
//   q    : synchronized output (last flop), STAGES cycles of latency
module dsync_chain #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ff <= {STAGES{RST_VAL}};
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/ddeglitch_rx.sv
// ddeglitch_rx: synchronizes an asynchronous buffered line and passes a level
// change to o only after it has been seen for N = max(filt_cnt,1) consecutive
// samples. Produces registered rise/fall pulses and counts aborted
// qualifications (glitches) in a saturating counter.
//   clk, rstb        : control clock, asynchronous active-low reset
//   CELV, CELG, SUB  : supply/ground/substrate pass-throughs, no logic function
//   bus.en           : filter enable (low forces IDLE, o held)
//   bus.i            : asynchronous line input
//   bus.filt_cnt     : qualify length, sampled every cycle
//   bus.glitch_clr   : synchronous clear of glitch_cnt (wins over increment)
//   bus.o            : filtered level
//   bus.o_rise/o_fall: one-cycle pulses, aligned with o's new value
//   bus.busy         : high while a qualification is in progress
//   bus.glitch_cnt   : saturating count of aborted qualifications
module ddeglitch_rx
   import ddeglitch_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_W      = FILT_W_DEF,
   parameter int   GCNT_W      = GCNT_W_DEF,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 CELV,
   input  logic                 CELG,
   input  logic                 SUB,
   ddeglitch_rx_if.slave        bus
);

   // Power pins exist only so the netlist carries them.
   logic unused_pwr;
   assign unused_pwr = CELV ^ CELG ^ SUB;

   logic              s;
   state_t            state, state_nxt;
   logic [FILT_W-1:0] cnt, cnt_nxt;
   logic              o_q, o_nxt;
   logic              rise_q, fall_q, busy_q;
   logic [GCNT_W-1:0] gcnt_q;
   logic              glitch_evt;
   logic [NW-1:0]     n_eff;
   logic [NW-1:0]     cnt_inc;

   dsync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_VAL)
   ) u_sync (
      .clk  (clk),
      .rstb (rstb),
      .d    (bus.i),
      .q    (s)
   );

   always_comb begin
      n_eff      = eff_n(NW'(bus.filt_cnt));
      cnt_inc    = NW'(cnt) + NW'(1);
      state_nxt  = state;
      cnt_nxt    = cnt;
      o_nxt      = o_q;
      glitch_evt = 1'b0;

      if (!bus.en) begin
         // Disabling aborts any qualification silently (not a glitch).
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end
            STABLE: begin
               if (s != o_q) begin
                  // First mismatching sample already satisfies N == 1.
                  if (n_eff <= NW'(1)) begin
                     o_nxt = s;
                  end else begin
                     state_nxt = QUAL;
                     cnt_nxt   = FILT_W'(1);
                  end
               end
            end
            QUAL: begin
               if (s != o_q) begin
                  // >= so that lowering filt_cnt mid-run completes at once.
                  if (cnt_inc >= n_eff) begin
                     o_nxt     = s;
                     cnt_nxt   = '0;
                     state_nxt = STABLE;
                  end else begin
                     cnt_nxt = cnt_inc[FILT_W-1:0];
                  end
               end else begin
                  cnt_nxt    = '0;
                  state_nxt  = STABLE;
                  glitch_evt = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state  <= IDLE;
         cnt    <= '0;
         o_q    <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         busy_q <= 1'b0;
         gcnt_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         o_q    <= o_nxt;
         // Pulses register together with o so they line up with its new value.
         rise_q <= o_nxt & ~o_q;
         fall_q <= ~o_nxt & o_q;
         busy_q <= (state_nxt == QUAL);
         if (bus.glitch_clr) begin
            gcnt_q <= '0;
         end else if (glitch_evt && !(&gcnt_q)) begin
            gcnt_q <= gcnt_q + GCNT_W'(1);
         end
      end
   end

   assign bus.o          = o_q;
   assign bus.o_rise     = rise_q;
   assign bus.o_fall     = fall_q;
   assign bus.busy       = busy_q;
   assign bus.glitch_cnt = gcnt_q;

endmodule
